// File: rtl/matrix_tx_formatter_if.sv
// Formatter bundle: start/size request, storage read port, UART TX byte handshake and status.
// master = the formatter, slave = its environment (requester, storage, UART TX).
interface matrix_tx_formatter_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [2:0]        rows;
  logic [2:0]        cols;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, rows, cols, mem_rdata, tx_ready,
    output mem_rd_en, mem_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, rows, cols, mem_rdata, tx_ready,
    input  mem_rd_en, mem_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/matrix_tx_formatter.sv
// Purpose: streams a stored matrix as ASCII decimal text (space separated, CR LF per row) to UART TX.
// Latency: first byte valid 3 cycles after start; 2 idle cycles (fetch, latch) between elements.
// Backpressure: one byte held stable on tx_data/tx_valid until tx_ready; no further buffering.
module matrix_tx_formatter #(
  parameter int ROWS_MAX = 5,
  parameter int COLS_MAX = 5,
  parameter int ADDR_W   = 5
) (
  input  logic                   clk,
  input  logic                   uart_tx_rst_n,
  matrix_tx_formatter_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, DIGIT, SEP, CR, LF, FIN
  } state_t;

  localparam logic [2:0] ROWS_CAP = 3'(ROWS_MAX);
  localparam logic [2:0] COLS_CAP = 3'(COLS_MAX);

  state_t          state, state_n;
  logic [2:0]      rows_q, cols_q;
  logic [2:0]      r_q, c_q;
  logic [2:0][3:0] dig_q;
  logic [1:0]      dig_idx;
  logic            zero_hold;
  logic [3:0]      cur_dig;
  logic [2:0]      rows_eff, cols_eff;
  logic            size_zero;

  assign rows_eff  = (bus.rows > ROWS_CAP) ? ROWS_CAP : bus.rows;
  assign cols_eff  = (bus.cols > COLS_CAP) ? COLS_CAP : bus.cols;
  assign size_zero = (rows_eff == 3'd0) || (cols_eff == 3'd0);

  always_comb begin
    case (dig_idx)
      2'd2:    cur_dig = dig_q[2];
      2'd1:    cur_dig = dig_q[1];
      default: cur_dig = dig_q[0];
    endcase
  end

  always_comb begin
    state_n       = state;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = size_zero ? FIN : FETCH;
      end
      FETCH: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = ADDR_W'(r_q) * ADDR_W'(COLS_MAX) + ADDR_W'(c_q);
        state_n       = LATCH;
      end
      LATCH: state_n = DIGIT;
      DIGIT: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h30 | {4'h0, cur_dig};
        if (bus.tx_ready && dig_idx == 2'd0)
          state_n = (c_q < cols_q - 3'd1) ? SEP : CR;
      end
      SEP: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h20;
        if (bus.tx_ready) state_n = FETCH;
      end
      CR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h0D;
        if (bus.tx_ready) state_n = LF;
      end
      LF: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h0A;
        if (bus.tx_ready) state_n = (r_q < rows_q - 3'd1) ? FETCH : FIN;
      end
      FIN: begin
        // A zero-size request spends one extra busy cycle here so done lands at start+2.
        if (zero_hold) begin
          bus.busy = 1'b1;
        end else begin
          bus.busy = 1'b0;
          bus.done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge uart_tx_rst_n) begin
    if (!uart_tx_rst_n) begin
      state     <= IDLE;
      rows_q    <= 3'd0;
      cols_q    <= 3'd0;
      r_q       <= 3'd0;
      c_q       <= 3'd0;
      dig_q     <= '0;
      dig_idx   <= 2'd0;
      zero_hold <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rows_q    <= rows_eff;
            cols_q    <= cols_eff;
            r_q       <= 3'd0;
            c_q       <= 3'd0;
            zero_hold <= size_zero;
          end
        end
        LATCH: begin
          dig_q[2] <= 4'(bus.mem_rdata / 8'd100);
          dig_q[1] <= 4'((bus.mem_rdata / 8'd10) % 8'd10);
          dig_q[0] <= 4'(bus.mem_rdata % 8'd10);
          // Start at the most significant non-zero digit; a zero value sends a single "0".
          if (bus.mem_rdata >= 8'd100)     dig_idx <= 2'd2;
          else if (bus.mem_rdata >= 8'd10) dig_idx <= 2'd1;
          else                             dig_idx <= 2'd0;
        end
        DIGIT: begin
          if (bus.tx_ready && dig_idx != 2'd0) dig_idx <= dig_idx - 2'd1;
        end
        SEP: begin
          if (bus.tx_ready) c_q <= c_q + 3'd1;
        end
        LF: begin
          if (bus.tx_ready) begin
            c_q <= 3'd0;
            r_q <= r_q + 3'd1;
          end
        end
        FIN: zero_hold <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_tx_formatter.sv
// Randomized scoreboard bench for matrix_tx_formatter: expected bytes and read addresses come from
// a string-formatting reference model; a negedge monitor pops and compares them.
module tb_matrix_tx_formatter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matrix_tx_formatter_if #(.ADDR_W(5)) bus ();

  matrix_tx_formatter #(.ROWS_MAX(5), .COLS_MAX(5), .ADDR_W(5)) dut (
    .clk           (clk),
    .uart_tx_rst_n (rst_n),
    .bus           (bus)
  );

  logic [7:0]   mem [32];
  byte unsigned exp_q[$];
  int           exp_addr_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  int           vld_cnt = 0;
  int           ready_mode = 0;
  int           cyc = 0;
  bit           hold_pend = 0;
  logic [7:0]   hold_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the text the matrix should print, plus the storage reads it implies.
  task automatic push_expected(input int rr, input int cc);
    int er, ec;
    string s;
    er = (rr > 5) ? 5 : rr;
    ec = (cc > 5) ? 5 : cc;
    if (er == 0 || ec == 0) return;
    for (int r = 0; r < er; r++) begin
      for (int c = 0; c < ec; c++) begin
        exp_addr_q.push_back(r * 5 + c);
        s = $sformatf("%0d", mem[r * 5 + c]);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (c < ec - 1) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Storage model: synchronous read port.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // UART TX ready pattern, changed just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    case (ready_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = (cyc % 4 == 0);
      default: bus.tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: outputs are stable at the falling edge; a valid&&ready seen here transfers next rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.tx_valid) vld_cnt++;
      if (hold_pend) begin
        chk("hold_valid", 32'(bus.tx_valid), 32'd1);
        chk("hold_data", 32'(bus.tx_data), 32'(hold_dat));
      end
      hold_pend = bus.tx_valid && !bus.tx_ready;
      hold_dat  = bus.tx_data;
      if (bus.mem_rd_en) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_read: got addr %0d, expected no read", bus.mem_addr);
        end else begin
          chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_byte: got %02h, expected no byte", bus.tx_data);
        end else begin
          chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic run_xfer(input int rr, input int cc, input int mode, input bit disturb);
    int  er, ec;
    bit  zero, got;
    er   = (rr > 5) ? 5 : rr;
    ec   = (cc > 5) ? 5 : cc;
    zero = (er == 0) || (ec == 0);
    ready_mode = mode;
    push_expected(rr, cc);
    done_cnt = 0;
    vld_cnt  = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.rows  = 3'(rr);
    bus.cols  = 3'(cc);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_n1", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    if (zero) begin
      chk("zero_done_n2", 32'(bus.done), 32'd1);
      chk("zero_busy_n2", 32'(bus.busy), 32'd0);
    end else begin
      chk("valid_low_n2", 32'(bus.tx_valid), 32'd0);
      @(posedge clk); #1;
      chk("first_valid_n3", 32'(bus.tx_valid), 32'd1);
      got = 0;
      for (int t = 0; t < 5000 && !got; t++) begin
        if (disturb && t == 5) begin
          bus.start = 1'b1;
          bus.rows  = 3'($urandom);
          bus.cols  = 3'($urandom);
        end
        if (disturb && t == 6) bus.start = 1'b0;
        if (bus.done) begin
          got = 1;
          chk("busy_with_done", 32'(bus.busy), 32'd0);
        end else begin
          @(posedge clk); #1;
        end
      end
      if (!got) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout: got no done, expected done within 5000 cycles");
      end
    end
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    chk("reads_left", 32'(exp_addr_q.size()), 32'd0);
    if (zero) chk("zero_no_valid", 32'(vld_cnt), 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.rows  = 3'd0;
    bus.cols  = 3'd0;
    foreach (mem[i]) mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;

    // 2x2 {1,20;255,0}, ready tied high
    mem[0] = 8'd1; mem[1] = 8'd20; mem[5] = 8'd255; mem[6] = 8'd0;
    run_xfer(2, 2, 0, 0);

    // 1x1 {0}, ready 1-in-4
    mem[0] = 8'd0;
    run_xfer(1, 1, 1, 0);

    // zero-size request
    run_xfer(0, 3, 0, 0);

    // clamped 7x7 -> 5x5 of nines
    foreach (mem[i]) mem[i] = 8'd9;
    run_xfer(7, 7, 0, 0);

    // start re-pulsed with new sizes mid-transfer
    foreach (mem[i]) mem[i] = 8'($urandom);
    run_xfer(4, 3, 2, 1);

    // reset during the second element, then a full clean run
    foreach (mem[i]) mem[i] = 8'($urandom_range(100, 255));
    ready_mode = 0;
    push_expected(3, 3);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.rows = 3'd3; bus.cols = 3'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (bus.mem_rd_en && bus.mem_addr == 5'd1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL second_fetch_timeout: got no read of addr 1, expected one");
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
    done_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_data", 32'(bus.tx_data), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);
    run_xfer(3, 3, 2, 0);

    // randomized sizes, values and ready patterns
    for (int k = 0; k < 6; k++) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      run_xfer($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_tx_formatter.md
# matrix_tx_formatter

Converts a stored matrix of unsigned 8-bit elements into an ASCII text stream and hands it byte-by-byte to the UART transmitter. It sits directly upstream of the UART TX byte interface: it reads elements from the matrix storage through a synchronous read port and drives the transmitter's byte/valid/ready handshake. One `start` pulse produces the whole matrix, row-major: decimal values, space-separated, each row terminated by CR LF.

## Interface
- `ROWS_MAX`, 5, maximum rows; larger `rows` requests are clamped to this.
- `COLS_MAX`, 5, maximum columns; larger `cols` requests are clamped to this.
- `ADDR_W`, 5, storage address width; must satisfy 2^ADDR_W ≥ ROWS_MAX*COLS_MAX.
- `clk`  in  1  system clock; all logic on the rising edge.
- `uart_tx_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to send the matrix; ignored while `busy`.
- `rows`  in  3  row count, sampled on accepted `start`.
- `cols`  in  3  column count, sampled on accepted `start`.
- `mem_rd_en`  out  1  storage read strobe.
- `mem_addr`  out  ADDR_W  element address = r*COLS_MAX + c.
- `mem_rdata`  in  8  element value, valid the cycle after `mem_rd_en`.
- `tx_data`  out  8  ASCII byte to the UART TX.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART TX can accept a byte (idle).
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at end of transfer.

## Operation
- States: IDLE, FETCH, LATCH, DIGIT, SEP, CR, LF, FIN.
- IDLE: on `start` with effective rows and cols both ≠ 0, latch clamped sizes, set r=c=0, go to FETCH. If either is 0, go directly to FIN; no bytes are emitted.
- FETCH: `mem_rd_en`=1, `mem_addr` = r*COLS_MAX + c; next state is LATCH.
- LATCH: capture `mem_rdata` and split it into hundreds/tens/units digits. The digit count is 3 for values ≥100, 2 for values ≥10, else 1, so there are no leading zeros and 0 sends "0". Next state is DIGIT.
- DIGIT: present the most significant remaining digit as 0x30+d. On handshake, advance to the next digit; after the last digit go to SEP if c < cols-1, else CR.
- SEP: send 0x20; on handshake, c++ and go to FETCH.
- CR: send 0x0D; on handshake go to LF.
- LF: send 0x0A; on handshake, c=0, r++. Go to FETCH if r < rows-1, else FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- Handshake: a byte transfers on the rising edge where `tx_valid`&&`tx_ready`. While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold stable. `tx_valid` never depends combinationally on `tx_ready`.
- `start` during `busy` is ignored and does not queue.
- Input size changes after `start` have no effect on the current transfer.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `mem_rd_en`=0, `mem_addr`=0, `busy`=0, `done`=0; state is IDLE.
- Reset mid-transfer: all outputs clear immediately (asynchronous). The partial stream is abandoned and there is no `done` pulse.
- `start` sampled at edge N gives:
  - `busy`=1 and FETCH in cycle N+1;
  - LATCH in N+2;
  - first `tx_valid`=1 in N+3.
- Between elements there are 2 cycles with `tx_valid`=0 (FETCH, LATCH) after the SEP or LF handshake.
- CR, LF, SEP and successive digits are back-to-back: `tx_valid` stays 1 across a handshake edge when the next byte is within the same element or terminator.
- `done` asserts the cycle after the final LF handshake; `busy` is 0 in the same cycle as `done`.
- Zero-size request: `done` in N+2, `busy` high only in N+1.
- Throughput is limited by `tx_ready`, with no internal buffering beyond one byte.

## Test plan
- 2x2 {1,20;255,0}, `tx_ready` tied 1 -> bytes 31 20 32 30 0D 0A 32 35 35 20 30 0D 0A. Exactly one `done`, and no `mem_rd_en` beyond addr 6.
- 1x1 {0}, `tx_ready` toggled 1-in-4 cycles -> bytes 30 0D 0A. `tx_data` is stable while valid and not ready.
- rows=0, cols=3 -> no `tx_valid` ever; `done` at N+2.
- rows=7, cols=7 (clamped to 5x5), all elements 9 -> 25 "9" digits, 20 spaces, 5 CR LF pairs. Addresses step 0..24.
- `start` re-pulsed mid-transfer and `rows`/`cols` changed -> output identical to the undisturbed run; a single `done`.
- `uart_tx_rst_n` low during the second element -> `tx_valid`/`busy` fall asynchronously. A new `start` after release produces a complete, correct stream from element 0.
